// File: rtl/multi_serializer_if.sv
// Handshake and serial-output bundle for multi_serializer.
// The DUT takes the slave modport; the producer/observer takes master.
interface multi_serializer_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
);
  logic [CHANNELS*WIDTH-1:0] data_in;
  logic [CHANNELS-1:0]       valid_in;
  logic [CHANNELS-1:0]       ready_out;
  logic                      serial_out;
  logic                      start;
  logic                      busy;
  logic                      done;

  modport master (
    output data_in, valid_in,
    input  ready_out, serial_out, start, busy, done
  );

  modport slave (
    input  data_in, valid_in,
    output ready_out, serial_out, start, busy, done
  );
endinterface

// File: rtl/multi_serializer.sv
// Round-robin multi-channel serializer: per-channel one-word holding registers
// feed MSB-first frames {channel ID, data, optional even parity} onto one line.
module multi_serializer #(
  parameter int WIDTH     = 8,
  parameter int CHANNELS  = 4,
  parameter int PARITY_EN = 1,
  parameter int DIV       = 1
) (
  input logic               clk,
  input logic               rst,
  multi_serializer_if.slave bus
);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int FL = CW + WIDTH + ((PARITY_EN != 0) ? 1 : 0);
  localparam int BW = $clog2(FL + 1);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {IDLE, ID, DATA, PAR} state_t;
  state_t state, state_nxt;

  logic [CHANNELS-1:0] full;
  logic [CHANNELS-1:0] accept;
  logic [CHANNELS-1:0] grant_mask;
  logic [WIDTH-1:0]    hold [CHANNELS];
  logic [CW-1:0]       last_grant;
  logic [CW-1:0]       gnt_idx;
  logic [CW-1:0]       cand;
  logic                any_full;
  logic [DW-1:0]       div_cnt;
  logic [BW-1:0]       bit_cnt;
  logic [FL-1:0]       shifter;
  logic [FL-1:0]       frame;
  logic                par_bit;
  logic                div_last;
  logic                field_last;
  logic                frame_end;
  logic                grant_go;
  logic                serial_q;
  logic                start_q;

  assign accept = bus.valid_in & ~full;

  // Round-robin search: descending loop so the smallest offset from last_grant wins.
  always_comb begin
    gnt_idx  = last_grant;
    cand     = '0;
    any_full = |full;
    for (int unsigned i = CHANNELS; i >= 1; i--) begin
      cand = CW'((32'(last_grant) + i) % CHANNELS);
      if (full[cand]) gnt_idx = cand;
    end
  end

  always_comb begin
    par_bit = ^{gnt_idx, hold[gnt_idx]};
    if (PARITY_EN != 0) frame = FL'({gnt_idx, hold[gnt_idx], par_bit});
    else                frame = FL'({gnt_idx, hold[gnt_idx]});
  end

  always_comb begin
    div_last = (div_cnt == DW'(DIV - 1));
    unique case (state)
      ID:      field_last = (bit_cnt == BW'(CW - 1));
      DATA:    field_last = (bit_cnt == BW'(WIDTH - 1));
      default: field_last = 1'b1;
    endcase
    frame_end = div_last && field_last &&
                ((state == PAR) || ((state == DATA) && (PARITY_EN == 0)));
    // A grant at frame end lets the next frame follow with no idle cycle.
    grant_go  = any_full && ((state == IDLE) || frame_end);
    grant_mask = '0;
    if (grant_go) grant_mask[gnt_idx] = 1'b1;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (any_full) state_nxt = ID;
      ID:   if (div_last && field_last) state_nxt = DATA;
      DATA: begin
        if (div_last && field_last) begin
          if (PARITY_EN != 0) state_nxt = PAR;
          else if (any_full)  state_nxt = ID;
          else                state_nxt = IDLE;
        end
      end
      PAR: begin
        if (div_last) begin
          if (any_full) state_nxt = ID;
          else          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.ready_out  = ~full;
    bus.serial_out = serial_q;
    bus.start      = start_q;
    bus.busy       = (state != IDLE);
    bus.done       = frame_end;
  end

  always_ff @(posedge clk) begin
    for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
      if (accept[ch]) hold[ch] <= bus.data_in[ch*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full       <= '0;
      last_grant <= CW'(CHANNELS - 1);
      div_cnt    <= '0;
      bit_cnt    <= '0;
      shifter    <= '0;
      serial_q   <= 1'b0;
      start_q    <= 1'b0;
    end else begin
      full <= (full | accept) & ~grant_mask;
      if (grant_go) begin
        last_grant <= gnt_idx;
        div_cnt    <= '0;
        bit_cnt    <= '0;
        serial_q   <= frame[FL-1];
        shifter    <= frame << 1;
        start_q    <= 1'b1;
      end else if (state != IDLE) begin
        if (div_last) begin
          div_cnt <= '0;
          bit_cnt <= field_last ? '0 : bit_cnt + 1'b1;
          start_q <= 1'b0;
          if (frame_end) begin
            serial_q <= 1'b0;
            shifter  <= '0;
          end else begin
            serial_q <= shifter[FL-1];
            shifter  <= shifter << 1;
          end
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end
    end
  end
endmodule
